// File: rtl/parallel_axis_vip_if.sv
// alpaca_data_pkt_axis: multi-sample complex AXI-Stream packet interface.
// Each beat carries SAMP_PER_CLK complex samples, with re in the low half of each sample.
interface alpaca_data_pkt_axis #(
    parameter int SAMP_W       = 16,
    parameter int SAMP_PER_CLK = 2,
    parameter int TUSER_W      = 1
);
    typedef struct packed {
        logic [SAMP_W-1:0] im;
        logic [SAMP_W-1:0] re;
    } cx_t;

    typedef cx_t [SAMP_PER_CLK-1:0] data_pkt_t;

    data_pkt_t          tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic [TUSER_W-1:0] tuser;

    modport MST (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport SLV (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/parallel_axis_vip.sv
// parallel_axis_vip: captures DEPTH beats of a multi-sample AXI-Stream into ram[],
// in arrival order, then raises a sticky full flag and stops accepting.
module parallel_axis_vip_chk #(
    parameter int WORD_W = 64
) (
    input logic              clk,
    input logic              rst,
    input logic              accept,
    input logic [WORD_W-1:0] tdata
);
    // An accepted beat must carry fully defined data
    a_tdata_known: assert property (@(posedge clk) disable iff (rst) accept |-> !$isunknown(tdata))
        else $error("parallel_axis_vip: X/Z on tdata during an accepted beat");
endmodule

module parallel_axis_vip #(
    parameter int DEPTH        = 64,
    parameter int SAMP_W       = 16,
    parameter int SAMP_PER_CLK = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    alpaca_data_pkt_axis.SLV         s_axis,
    output logic                     full
);
    localparam int WORD_W = SAMP_PER_CLK * 2 * SAMP_W;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = AW + 1;

    logic [WORD_W-1:0] ram [0:DEPTH-1];
    logic [PTR_W-1:0]  wr_ptr;
    logic              full_r;
    logic              tready_s;
    logic              accept_s;
    logic [WORD_W-1:0] tdata_s;
    logic              unused_s;

    // Reset blocks acceptance so a beat presented during rst is never written
    assign tready_s      = ~full_r & ~rst;
    assign s_axis.tready = tready_s;
    assign accept_s      = s_axis.tvalid & tready_s;
    assign tdata_s       = s_axis.tdata;
    assign full          = full_r;
    assign unused_s      = ^{s_axis.tlast, s_axis.tuser};

    // Write pointer and sticky full flag; pointer stops at DEPTH and never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            full_r <= 1'b0;
        end else if (accept_s) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (wr_ptr == PTR_W'(DEPTH - 1)) begin
                full_r <= 1'b1;
            end else begin
                full_r <= full_r;
            end
        end else begin
            wr_ptr <= wr_ptr;
            full_r <= full_r;
        end
    end

    // Capture RAM; deliberately not reset so earlier captures survive rst
    always_ff @(posedge clk) begin
        if (accept_s) begin
            ram[wr_ptr[AW-1:0]] <= tdata_s;
        end
    end

    parallel_axis_vip_chk #(.WORD_W(WORD_W)) u_chk (
        .clk    (clk),
        .rst    (rst),
        .accept (accept_s),
        .tdata  (tdata_s)
    );
endmodule

// File: tb/tb_parallel_axis_vip.sv
// Self-checking bench for parallel_axis_vip: directed capture sequences and a
// table of single-cycle vectors around reset and a mid-capture restart.
module tb_parallel_axis_vip;
    localparam int DEPTH = 64;

    typedef struct {
        logic        rst;
        logic        tvalid;
        logic [63:0] data;
        logic        exp_tready;
        logic [6:0]  exp_ptr;
        logic        exp_full;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic full;
    int   errors = 0;
    int   checks = 0;
    vec_t tab [0:12];

    always #5 clk = ~clk;

    alpaca_data_pkt_axis #(.SAMP_W(16), .SAMP_PER_CLK(2), .TUSER_W(1)) axis ();

    parallel_axis_vip #(.DEPTH(DEPTH), .SAMP_W(16), .SAMP_PER_CLK(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axis (axis),
        .full   (full)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // counting stream: sample s has re=2s, im=2s+1; beat k holds samples 2k, 2k+1
    function automatic logic [63:0] word1(input int k);
        return {16'(4*k + 3), 16'(4*k + 2), 16'(4*k + 1), 16'(4*k)};
    endfunction

    function automatic logic [63:0] word3(input int n);
        return {8'h3c, 24'(n * 7), 16'(n), 16'hffff - 16'(n)};
    endfunction

    initial begin
        int c;
        int n;

        rst          = 1'b1;
        axis.tvalid  = 1'b0;
        axis.tdata   = '0;
        axis.tlast   = 1'b0;
        axis.tuser   = '0;
        @(negedge clk);
        tick();
        check("reset_full", full, 64'd0);
        check("reset_ptr", dut.wr_ptr, 64'd0);
        check("reset_tready", axis.tready, 64'd0);
        rst = 1'b0;
        #1 check("tready_after_reset", axis.tready, 64'd1);

        // Test 1: continuous counting stream, full exactly 64 clocks after first accept
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            axis.tvalid = 1'b1;
            axis.tdata  = word1(k);
            if (k == DEPTH - 1) begin
                #1;
                check("t1_full_before_last", full, 64'd0);
                check("t1_tready_before_last", axis.tready, 64'd1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("t1_full_after_64", full, 64'd1);
        check("t1_tready_after_full", axis.tready, 64'd0);
        check("t1_ptr_after_full", dut.wr_ptr, 64'd64);

        // Test 5: tvalid held after full, nothing changes
        axis.tdata = 64'hffff_ffff_ffff_ffff;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_full_held", full, 64'd1);
            check("t5_tready_low", axis.tready, 64'd0);
        end
        check("t5_ptr_held", dut.wr_ptr, 64'd64);
        for (int k = 0; k < DEPTH; k++) check($sformatf("t1_ram[%0d]", k), dut.ram[k], word1(k));

        // Test 6: rst and tvalid together, reset wins and nothing is written
        rst         = 1'b1;
        axis.tvalid = 1'b1;
        axis.tdata  = 64'haaaa_aaaa_aaaa_aaaa;
        #1 check("t6_tready_in_rst", axis.tready, 64'd0);
        tick();
        check("t6_ram0_unchanged", dut.ram[0], word1(0));
        check("t6_ptr", dut.wr_ptr, 64'd0);
        check("t6_full", full, 64'd0);
        rst = 1'b0;

        // Test 2: dead-beef packet lands in ram[0] with re low, im high
        axis.tvalid       = 1'b1;
        axis.tdata        = '0;
        axis.tdata[0].re  = 16'hbeef;
        axis.tdata[0].im  = 16'hdead;
        axis.tdata[1].re  = 16'h5678;
        axis.tdata[1].im  = 16'h1234;
        tick();
        check("t2_ram0_lo", dut.ram[0][31:0], 64'h0000_0000_dead_beef);
        check("t2_ram0_hi", dut.ram[0][63:32], 64'h0000_0000_1234_5678);
        check("t2_ptr", dut.wr_ptr, 64'd1);

        // Test 4 vectors: nine more accepts, a gap, a reset pulse, then a restart
        for (int i = 0; i < 9; i++) begin
            tab[i] = '{1'b0, 1'b1, {16'hc0de, 16'(i), 16'h5a5a, 16'(i * 3)}, 1'b1, 7'(i + 2), 1'b0};
        end
        tab[9]  = '{1'b0, 1'b0, 64'hdead_dead_dead_dead, 1'b1, 7'd10, 1'b0};
        tab[10] = '{1'b1, 1'b1, 64'hffff_ffff_ffff_ffff, 1'b0, 7'd0, 1'b0};
        tab[11] = '{1'b0, 1'b1, 64'h0123_4567_89ab_cdef, 1'b1, 7'd1, 1'b0};
        tab[12] = '{1'b0, 1'b0, 64'h5555_5555_5555_5555, 1'b1, 7'd1, 1'b0};
        for (int i = 0; i < 13; i++) begin
            rst         = tab[i].rst;
            axis.tvalid = tab[i].tvalid;
            axis.tdata  = tab[i].data;
            #1 check($sformatf("vec%0d_tready", i), axis.tready, 64'(tab[i].exp_tready));
            tick();
            check($sformatf("vec%0d_ptr", i), dut.wr_ptr, 64'(tab[i].exp_ptr));
            check($sformatf("vec%0d_full", i), full, 64'(tab[i].exp_full));
        end
        rst         = 1'b0;
        axis.tvalid = 1'b0;
        check("t4_ram0_restart", dut.ram[0], 64'h0123_4567_89ab_cdef);
        for (int i = 0; i < 9; i++) check($sformatf("t4_ram[%0d]", i + 1), dut.ram[i + 1], tab[i].data);
        for (int k = 10; k < DEPTH; k++) check($sformatf("t4_old_ram[%0d]", k), dut.ram[k], word1(k));

        // Test 3: tvalid toggling 1-0-1-0, 64 valid beats stored contiguously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c   = 0;
        n   = 0;
        while (!full && c < 400) begin
            axis.tvalid = (c % 2 == 0);
            axis.tdata  = (c % 2 == 0) ? word3(n) : 64'h0bad_0bad_0bad_0bad;
            if (c % 2 == 0) n++;
            tick();
            c++;
        end
        axis.tvalid = 1'b0;
        check("t3_cycles_to_full", 64'(c), 64'd127);
        check("t3_valid_beats", 64'(n), 64'd64);
        check("t3_tready_low", axis.tready, 64'd0);
        for (int k = 0; k < DEPTH; k++) check($sformatf("t3_ram[%0d]", k), dut.ram[k], word3(k));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
